// File: rtl/ddr_bank_sched.sv
// In-order multi-bank DDR4 command scheduler with open-page policy and tRCD/tRAS/tRP/tCCD timers.
// Optional auto-precharge (RDA/WRA) support is enabled by defining DDR_SCHED_AUTO_PRE_EN.
module ddr_bank_sched #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned ROW_W       = 15,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned CNT_W       = 6,
  localparam int unsigned BANK_W     = $clog2(NUM_BANKS),
  localparam int unsigned QA_W       = $clog2(QUEUE_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic              req_auto_pre,
  input  logic [CNT_W-1:0]  t_rcd,
  input  logic [CNT_W-1:0]  t_ras,
  input  logic [CNT_W-1:0]  t_rp,
  input  logic [CNT_W-1:0]  t_ccd,
  output logic              cmd_valid,
  output logic [2:0]        cmd_type,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              dev_busy
);

  typedef enum logic [2:0] {
    CmdNop = 3'd0, CmdAct = 3'd1, CmdRd = 3'd2, CmdWr = 3'd3,
    CmdPre = 3'd4, CmdRda = 3'd5, CmdWra = 3'd6
  } cmd_e;

  localparam logic [QA_W:0] QFull = (QA_W + 1)'(QUEUE_DEPTH);

  // Timers hold (cycles - 1) so a zero value means the gated command may issue this cycle.
  function automatic logic [CNT_W-1:0] ld_val(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [CNT_W:0] eff(input logic [CNT_W-1:0] t);
    return (t == '0) ? (CNT_W + 1)'(1) : {1'b0, t};
  endfunction

  // Queue storage (no reset needed; validity is tracked by count_q)
  logic              q_write_q [QUEUE_DEPTH];
  logic [BANK_W-1:0] q_bank_q  [QUEUE_DEPTH];
  logic [ROW_W-1:0]  q_row_q   [QUEUE_DEPTH];
  logic [COL_W-1:0]  q_col_q   [QUEUE_DEPTH];
  logic [QA_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [QA_W:0]     count_q, count_d;

  logic              open_q     [NUM_BANKS], open_d     [NUM_BANKS];
  logic [ROW_W-1:0]  open_row_q [NUM_BANKS], open_row_d [NUM_BANKS];
  logic [CNT_W-1:0]  rcd_tmr_q  [NUM_BANKS], rcd_tmr_d  [NUM_BANKS];
  logic [CNT_W-1:0]  ras_tmr_q  [NUM_BANKS], ras_tmr_d  [NUM_BANKS];
  logic [CNT_W:0]    rp_tmr_q   [NUM_BANKS], rp_tmr_d   [NUM_BANKS];
  logic [CNT_W-1:0]  ccd_tmr_q, ccd_tmr_d;

  cmd_e              cmd_type_q, cmd_type_d;
  logic [BANK_W-1:0] cmd_bank_q, cmd_bank_d;
  logic [ROW_W-1:0]  cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]  cmd_col_q, cmd_col_d;
  logic              cmd_valid_q;

  logic              enq, head_valid, do_act, do_pre, do_cas, tmr_busy;
  logic              h_write, h_ap;
  logic [BANK_W-1:0] h_bank;
  logic [ROW_W-1:0]  h_row;
  logic [COL_W-1:0]  h_col;
  logic [CNT_W:0]    rda_rp;

  assign req_ready  = (count_q != QFull);
  assign enq        = req_valid && req_ready;
  assign head_valid = (count_q != '0);
  assign h_write    = q_write_q[rd_ptr_q];
  assign h_bank     = q_bank_q[rd_ptr_q];
  assign h_row      = q_row_q[rd_ptr_q];
  assign h_col      = q_col_q[rd_ptr_q];
  assign rda_rp     = eff(t_ccd) + eff(t_rp) - (CNT_W + 1)'(1);

`ifdef DDR_SCHED_AUTO_PRE_EN
  logic q_ap_q [QUEUE_DEPTH];
  always_ff @(posedge clock) begin
    if (enq) q_ap_q[wr_ptr_q] <= req_auto_pre;
  end
  assign h_ap = q_ap_q[rd_ptr_q];
`else
  logic unused_auto_pre;
  assign unused_auto_pre = req_auto_pre;
  assign h_ap = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (enq) begin
      q_write_q[wr_ptr_q] <= req_write;
      q_bank_q[wr_ptr_q]  <= req_bank;
      q_row_q[wr_ptr_q]   <= req_row;
      q_col_q[wr_ptr_q]   <= req_col;
    end
  end

  // Head-of-queue decision; only the head's bank is ever considered
  always_comb begin
    do_act = 1'b0;
    do_pre = 1'b0;
    do_cas = 1'b0;
    if (head_valid) begin
      if (open_q[h_bank]) begin
        if (open_row_q[h_bank] == h_row) begin
          do_cas = (rcd_tmr_q[h_bank] == '0) && (ccd_tmr_q == '0);
        end else begin
          do_pre = (ras_tmr_q[h_bank] == '0);
        end
      end else begin
        do_act = (rp_tmr_q[h_bank] == '0);
      end
    end
  end

  always_comb begin
    cmd_type_d = CmdNop;
    cmd_bank_d = '0;
    cmd_row_d  = '0;
    cmd_col_d  = '0;
    if (do_act) begin
      cmd_type_d = CmdAct;
      cmd_bank_d = h_bank;
      cmd_row_d  = h_row;
    end else if (do_pre) begin
      cmd_type_d = CmdPre;
      cmd_bank_d = h_bank;
      cmd_row_d  = open_row_q[h_bank];
    end else if (do_cas) begin
      cmd_type_d = h_write ? (h_ap ? CmdWra : CmdWr) : (h_ap ? CmdRda : CmdRd);
      cmd_bank_d = h_bank;
      cmd_row_d  = h_row;
      cmd_col_d  = h_col;
    end
  end

  always_comb begin
    count_d = count_q + (QA_W + 1)'(enq) - (QA_W + 1)'(do_cas);
    for (int b = 0; b < NUM_BANKS; b++) begin
      open_d[b]     = open_q[b];
      open_row_d[b] = open_row_q[b];
      rcd_tmr_d[b]  = (rcd_tmr_q[b] != '0) ? rcd_tmr_q[b] - 1'b1 : '0;
      ras_tmr_d[b]  = (ras_tmr_q[b] != '0) ? ras_tmr_q[b] - 1'b1 : '0;
      rp_tmr_d[b]   = (rp_tmr_q[b] != '0) ? rp_tmr_q[b] - 1'b1 : '0;
    end
    ccd_tmr_d = (ccd_tmr_q != '0) ? ccd_tmr_q - 1'b1 : '0;
    if (do_act) begin
      open_d[h_bank]     = 1'b1;
      open_row_d[h_bank] = h_row;
      rcd_tmr_d[h_bank]  = ld_val(t_rcd);
      ras_tmr_d[h_bank]  = ld_val(t_ras);
    end
    if (do_pre) begin
      open_d[h_bank]   = 1'b0;
      rp_tmr_d[h_bank] = {1'b0, ld_val(t_rp)};
    end
    if (do_cas) begin
      ccd_tmr_d = ld_val(t_ccd);
      if (h_ap) begin
        open_d[h_bank]   = 1'b0;
        rp_tmr_d[h_bank] = rda_rp;
      end
    end
  end

  always_comb begin
    tmr_busy = (ccd_tmr_q != '0);
    for (int b = 0; b < NUM_BANKS; b++) begin
      tmr_busy = tmr_busy || (rcd_tmr_q[b] != '0) || (ras_tmr_q[b] != '0) ||
                 (rp_tmr_q[b] != '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ccd_tmr_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CmdNop;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        open_q[b]     <= 1'b0;
        open_row_q[b] <= '0;
        rcd_tmr_q[b]  <= '0;
        ras_tmr_q[b]  <= '0;
        rp_tmr_q[b]   <= '0;
      end
    end else begin
      if (enq)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_cas) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      ccd_tmr_q   <= ccd_tmr_d;
      cmd_valid_q <= (cmd_type_d != CmdNop);
      cmd_type_q  <= cmd_type_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        open_q[b]     <= open_d[b];
        open_row_q[b] <= open_row_d[b];
        rcd_tmr_q[b]  <= rcd_tmr_d[b];
        ras_tmr_q[b]  <= ras_tmr_d[b];
        rp_tmr_q[b]   <= rp_tmr_d[b];
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign dev_busy  = head_valid || tmr_busy;

endmodule

// File: tb/tb_ddr_bank_sched.sv
// Self-checking bench for ddr_bank_sched: directed scenarios plus random traffic checked
// against a timestamp-based reference model of the scheduling rules.
module tb_ddr_bank_sched;
  localparam int NB = 4;
  localparam int QD = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_auto_pre;
  logic [1:0]  req_bank;
  logic [14:0] req_row;
  logic [9:0]  req_col;
  logic [5:0]  t_rcd, t_ras, t_rp, t_ccd;
  logic        cmd_valid, dev_busy;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;

  ddr_bank_sched dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_auto_pre(req_auto_pre), .t_rcd(t_rcd), .t_ras(t_ras), .t_rp(t_rp), .t_ccd(t_ccd),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .dev_busy(dev_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit w;
    int bank;
    int row;
    int col;
    bit ap;
  } req_t;

  int   checks = 0;
  int   failures = 0;
  int   e;
  req_t mq[$];
  bit   m_open [NB];
  int   m_row [NB];
  // Earliest cycle at which each command class becomes legal again
  int   cas_ok [NB];
  int   pre_ok [NB];
  int   act_ok [NB];
  int   ccd_ok;
  int   last_type;

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d actual=%0h required=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 0; m_row[b] = 0; cas_ok[b] = 0; pre_ok[b] = 0; act_ok[b] = 0;
    end
    ccd_ok = 0;
    e = 0;
  endtask

  task automatic step(input bit v, input bit w, input int b, input int r, input int c,
                      input bit ap, output bit acc);
    int   et, eb, er, ec, hb;
    bit   busy;
    req_t h, n;
    @(negedge clock);
    req_valid = v; req_write = w; req_bank = 2'(b); req_row = 15'(r);
    req_col = 10'(c); req_auto_pre = ap;
    e++;
    et = 0; eb = 0; er = 0; ec = 0;
    if (mq.size() != 0) begin
      h = mq[0];
      hb = h.bank;
      if (m_open[hb]) begin
        if (m_row[hb] == h.row) begin
          if (e >= cas_ok[hb] && e >= ccd_ok) begin
            et = h.w ? (h.ap ? 6 : 3) : (h.ap ? 5 : 2);
            eb = hb; er = h.row; ec = h.col;
            ccd_ok = e + eff(int'(t_ccd));
            if (h.ap) begin
              m_open[hb] = 0;
              act_ok[hb] = e + eff(int'(t_ccd)) + eff(int'(t_rp));
            end
          end
        end else if (e >= pre_ok[hb]) begin
          et = 4; eb = hb; er = m_row[hb];
          m_open[hb] = 0;
          act_ok[hb] = e + eff(int'(t_rp));
        end
      end else if (e >= act_ok[hb]) begin
        et = 1; eb = hb; er = h.row;
        m_open[hb] = 1; m_row[hb] = h.row;
        cas_ok[hb] = e + eff(int'(t_rcd));
        pre_ok[hb] = e + eff(int'(t_ras));
      end
    end
    acc = v && (mq.size() != QD);
    @(posedge clock);
    #1;
    if (et == 2 || et == 3 || et == 5 || et == 6) void'(mq.pop_front());
    if (acc) begin
      n.w = w; n.bank = b; n.row = r; n.col = c;
`ifdef DDR_SCHED_AUTO_PRE_EN
      n.ap = ap;
`else
      n.ap = 0;
`endif
      mq.push_back(n);
    end
    busy = (mq.size() != 0) || (ccd_ok > e + 1);
    for (int k = 0; k < NB; k++)
      busy = busy || (cas_ok[k] > e + 1) || (pre_ok[k] > e + 1) || (act_ok[k] > e + 1);
    last_type = et;
    chk("cmd_valid", 32'(cmd_valid), 32'(et != 0));
    chk("cmd_type", 32'(cmd_type), 32'(et));
    chk("cmd_bank", 32'(cmd_bank), 32'(eb));
    chk("cmd_row", 32'(cmd_row), 32'(er));
    chk("cmd_col", 32'(cmd_col), 32'(ec));
    chk("req_ready", 32'(req_ready), 32'(mq.size() != QD));
    chk("dev_busy", 32'(dev_busy), 32'(busy));
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic send(input bit w, input int b, input int r, input int c, input bit ap);
    bit a;
    a = 0;
    for (int i = 0; i < 200 && !a; i++) step(1, w, b, r, c, ap, a);
    if (!a) begin
      checks++;
      assert (a) else begin
        failures++;
        $error("FAIL accept_timeout actual=0 required=1");
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(0));
    chk({tag, "_cmd_type"}, 32'(cmd_type), 32'(0));
    chk({tag, "_cmd_addr"}, {cmd_bank, cmd_row, cmd_col}, 32'(0));
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_dev_busy"}, 32'(dev_busy), 32'(0));
  endtask

  initial begin
    bit a;
    int guard;
    reset_n = 1'b0; req_valid = 0; req_write = 0; req_bank = '0; req_row = '0;
    req_col = '0; req_auto_pre = 0;
    t_rcd = 6'd4; t_ras = 6'd4; t_rp = 6'd2; t_ccd = 6'd4;
    #1;
    reset_checks("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    // Closed-bank read, then row-hit pair on another bank
    send(0, 0, 5, 8, 0);
    idle(10);
    send(0, 1, 3, 0, 0);
    send(0, 1, 3, 8, 0);
    idle(15);

    // Row miss on bank 2 gated by tRAS then tRP
    t_ras = 6'd10; t_rp = 6'd3;
    send(0, 2, 1, 0, 0);
    send(0, 2, 9, 0, 0);
    idle(25);

    // Queue fill while tRCD holds the head back
    t_rcd = 6'd63; t_ras = 6'd1;
    for (int i = 0; i < 9; i++) send(0, 3, 0, i, 0);
    idle(110);

    // Auto-precharge write followed by a read to the same row
    t_rcd = 6'd2; t_ccd = 6'd4; t_rp = 6'd3;
    send(1, 3, 2, 4, 1);
    send(0, 3, 2, 5, 0);
    idle(20);

    // Zero timing values behave as one
    t_rcd = 6'd0; t_ras = 6'd0; t_rp = 6'd0; t_ccd = 6'd0;
    send(0, 0, 7, 1, 0);
    send(0, 0, 7, 2, 1);
    send(1, 0, 8, 3, 0);
    idle(8);

    // Asynchronous reset between ACT and RD
    t_rcd = 6'd10;
    send(0, 1, 12, 0, 0);
    guard = 0;
    while (last_type != 1 && guard < 20) begin
      step(0, 0, 0, 0, 0, 0, a);
      guard++;
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    reset_checks("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    idle(4);

    // Random traffic with timing changes
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        t_rcd = 6'($urandom_range(0, 6)); t_ras = 6'($urandom_range(0, 9));
        t_rp = 6'($urandom_range(0, 5)); t_ccd = 6'($urandom_range(0, 5));
      end
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, NB - 1),
           $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 3) == 0, a);
    end
    idle(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
